// File: rtl/pv_sample_averager_if.sv
// Bus bundle for pv_sample_averager: sensor frame strobe in, windowed averages,
// status and FSM debug state out.
interface pv_sample_averager_if;
  // Strobe semantics: frame is sampled on the clk edge where frame_valid=1; there
  // is no backpressure, so every strobe is consumed. avg_valid is a one-cycle
  // strobe and the average outputs hold until the next strobe.
  logic [23:0] frame;
  logic        frame_valid;
  logic [7:0]  v_panel_avg;
  logic [7:0]  i_panel_avg;
  logic [7:0]  v_cap_avg;
  logic [15:0] power_avg;
  logic        avg_valid;
  logic        filled;
  logic [7:0]  err_count;
  logic        stale;
  logic        fsm_state;

  modport master (
    output frame, frame_valid,
    input  v_panel_avg, i_panel_avg, v_cap_avg, power_avg,
    input  avg_valid, filled, err_count, stale, fsm_state
  );

  modport slave (
    input  frame, frame_valid,
    output v_panel_avg, i_panel_avg, v_cap_avg, power_avg,
    output avg_valid, filled, err_count, stale, fsm_state
  );
endinterface

// File: rtl/pv_sample_averager.sv
// Moving-window averager for PV panel voltage/current and cap voltage frames.
// Optional stale-data timeout is built only when PV_STALE_TIMEOUT_EN is defined.
module pv_sample_averager #(
  parameter int LOG2_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input logic                clk,
  input logic                rst,
  pv_sample_averager_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 8 + LOG2_DEPTH;

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pv_sample_averager: illegal LOG2_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic [7:0]            buf_v [DEPTH];
  logic [7:0]            buf_i [DEPTH];
  logic [7:0]            buf_c [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [SW-1:0]         sum_v, sum_i, sum_c;
  logic [7:0]            new_v, new_i, new_c;
  logic [7:0]            avg_v, avg_i, avg_c;
  logic [7:0]            avg_v_nxt, avg_i_nxt, avg_c_nxt;
  logic [15:0]           power_q, power_nxt;
  logic [7:0]            err_q;
  logic                  accept, rejected, last_fill, pend_q, valid_q;

  assign new_v = bus.frame[23:16];
  assign new_i = bus.frame[15:8];
  assign new_c = bus.frame[7:0];

  // A saturated byte means the ADC clipped or the bus idled high mid-frame.
  assign rejected  = bus.frame_valid && (new_v == 8'hFF || new_i == 8'hFF || new_c == 8'hFF);
  assign accept    = bus.frame_valid && !rejected;
  assign last_fill = (wr_ptr == {LOG2_DEPTH{1'b1}});

  assign avg_v_nxt = sum_v[SW-1:LOG2_DEPTH];
  assign avg_i_nxt = sum_i[SW-1:LOG2_DEPTH];
  assign avg_c_nxt = sum_c[SW-1:LOG2_DEPTH];
  assign power_nxt = 16'(avg_v_nxt) * 16'(avg_i_nxt);

  always_comb begin
    state_d = state_q;
    if (state_q == FILL && accept && last_fill) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_v[k] <= '0;
        buf_i[k] <= '0;
        buf_c[k] <= '0;
      end
      wr_ptr  <= '0;
      sum_v   <= '0;
      sum_i   <= '0;
      sum_c   <= '0;
      avg_v   <= '0;
      avg_i   <= '0;
      avg_c   <= '0;
      power_q <= '0;
      err_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        sum_v         <= sum_v - SW'(buf_v[wr_ptr]) + SW'(new_v);
        sum_i         <= sum_i - SW'(buf_i[wr_ptr]) + SW'(new_i);
        sum_c         <= sum_c - SW'(buf_c[wr_ptr]) + SW'(new_c);
        buf_v[wr_ptr] <= new_v;
        buf_i[wr_ptr] <= new_i;
        buf_c[wr_ptr] <= new_c;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      // The frame that completes the window already counts as a RUN frame.
      pend_q <= accept && (state_q == RUN || last_fill);
      if (pend_q) begin
        avg_v   <= avg_v_nxt;
        avg_i   <= avg_i_nxt;
        avg_c   <= avg_c_nxt;
        power_q <= power_nxt;
      end
      valid_q <= pend_q;
      if (rejected && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

`ifdef PV_STALE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                                 to_cnt <= '0;
    else if (accept)                          to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))   to_cnt <= to_cnt + 1'b1;
  end

  assign bus.stale = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign bus.stale = 1'b0;
`endif

  assign bus.v_panel_avg = avg_v;
  assign bus.i_panel_avg = avg_i;
  assign bus.v_cap_avg   = avg_c;
  assign bus.power_avg   = power_q;
  assign bus.avg_valid   = valid_q;
  assign bus.filled      = (state_q == RUN);
  assign bus.err_count   = err_q;
  assign bus.fsm_state   = state_q;
endmodule
